// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - short/long interval timer with synchronized car sensor; define CAR_DEBOUNCE_EN to build the car debounce path
module interval_timer #(
  parameter int WIDTH = 8,
  parameter int SHORT = 5,
  parameter int LONG  = 25,
  parameter int DEB   = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             IC,
  input  logic             CAR,
  output logic             S,
  output logic             L,
  output logic             C,
  output logic [WIDTH-1:0] CNT
);

  // Reject parameter sets where the saturating counter cannot reach LONG or the intervals are inverted
  if (!(SHORT >= 1 && SHORT < LONG && LONG <= (1 << WIDTH) - 1 && DEB >= 1)) begin : g_bad_params
    $error("interval_timer: need 1 <= SHORT < LONG <= 2^WIDTH-1 and DEB >= 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sy1_q, sy2_q;

  // Next count: IC clears, otherwise count up and stick at LONG
  always_comb begin
    cnt_d = cnt_q;
    if (IC) begin
      cnt_d = '0;
    end else if (cnt_q != WIDTH'(LONG)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Interval counter register; CLR overrides IC
  always_ff @(posedge clk) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Two-flop synchronizer for the asynchronous car sensor
  always_ff @(posedge clk) begin
    if (!CLR) begin
      sy1_q <= 1'b0;
      sy2_q <= 1'b0;
    end else begin
      sy1_q <= CAR;
      sy2_q <= sy1_q;
    end
  end

`ifdef CAR_DEBOUNCE_EN
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

  logic [DW-1:0] db_q;
  logic          c_q;

  // Debounce: C follows SY2 only after DEB consecutive cycles of disagreement
  always_ff @(posedge clk) begin
    if (!CLR) begin
      db_q <= '0;
      c_q  <= 1'b0;
    end else if (sy2_q != c_q) begin
      if (db_q == DW'(DEB - 1)) begin
        db_q <= '0;
        c_q  <= ~c_q;
      end else begin
        db_q <= db_q + DW'(1);
      end
    end else begin
      db_q <= '0;
    end
  end

  assign C = c_q;
`else
  assign C = sy2_q;
`endif

  // Status flags decode straight from the count register
  assign S   = (cnt_q >= WIDTH'(SHORT));
  assign L   = (cnt_q >= WIDTH'(LONG));
  assign CNT = cnt_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - directed self-checking bench for interval_timer
module tb_interval_timer;

  logic       clk;
  logic       CLR;
  logic       IC;
  logic       CAR;
  logic       S;
  logic       L;
  logic       C;
  logic [7:0] CNT;

  int compared;
  int mismatched;

  interval_timer #(.WIDTH(8), .SHORT(5), .LONG(25), .DEB(4)) dut (
    .clk(clk),
    .CLR(CLR),
    .IC (IC),
    .CAR(CAR),
    .S  (S),
    .L  (L),
    .C  (C),
    .CNT(CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    CLR = 1'b0;
    IC  = 1'b0;
    CAR = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_cnt", 32'(CNT), 0);
    chk("rst_s", 32'(S), 0);
    chk("rst_l", 32'(L), 0);
    chk("rst_c", 32'(C), 0);

    // One-cycle IC pulse, count up to LONG and saturate
    CLR = 1'b1;
    IC  = 1'b1;
    step();
    chk("pulse_cnt0", 32'(CNT), 0);
    IC = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("ramp_cnt", 32'(CNT), 32'(k));
      chk("ramp_s", 32'(S), (k >= 5) ? 1 : 0);
      chk("ramp_l", 32'(L), (k >= 25) ? 1 : 0);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk("sat_cnt", 32'(CNT), 25);
      chk("sat_l", 32'(L), 1);
    end
    IC = 1'b1;
    step();
    chk("sat_clr_cnt", 32'(CNT), 0);
    chk("sat_clr_l", 32'(L), 0);

    // IC mid-count restarts the short interval
    IC = 1'b0;
    for (int k = 0; k < 11; k++) step();
    chk("mid_cnt11", 32'(CNT), 11);
    chk("mid_s11", 32'(S), 1);
    IC = 1'b1;
    step();
    chk("mid_clr_cnt", 32'(CNT), 0);
    chk("mid_clr_s", 32'(S), 0);
    IC = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_s4", 32'(S), 0);
    step();
    chk("mid_s5", 32'(S), 1);

    // IC held high for 30 cycles
    IC = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("hold_cnt", 32'(CNT), 0);
      chk("hold_s", 32'(S), 0);
      chk("hold_l", 32'(L), 0);
    end
    IC = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rel_s_low", 32'(S), 0);
    end
    step();
    chk("rel_s_high", 32'(S), 1);

    // CLR at CNT=20 with car present
    IC  = 1'b1;
    CAR = 1'b1;
    step();
    IC = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("pre_clr_cnt", 32'(CNT), 20);
    chk("pre_clr_c", 32'(C), 1);
    CLR = 1'b0;
    step();
    chk("clr_cnt", 32'(CNT), 0);
    chk("clr_s", 32'(S), 0);
    chk("clr_l", 32'(L), 0);
    chk("clr_c", 32'(C), 0);
    CLR = 1'b1;
    IC  = 1'b1;
    step();
    chk("post_clr_ic_cnt", 32'(CNT), 0);
    chk("post_clr_c", 32'(C), 0);
    IC  = 1'b0;
    CAR = 1'b0;
    step();
    chk("post_clr_cnt1", 32'(CNT), 1);
    step();
    step();
    chk("car_idle_c", 32'(C), 0);

`ifdef CAR_DEBOUNCE_EN
    // Three-cycle glitch is suppressed
    CAR = 1'b1;
    step();
    step();
    step();
    CAR = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch_c", 32'(C), 0);
    end
    // Sustained car: C rises after edge 5
    CAR = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("db_c_low", 32'(C), 0);
    end
    step();
    chk("db_c_high", 32'(C), 1);
    IC = 1'b1;
    step();
    chk("db_ic_indep", 32'(C), 1);
    IC = 1'b0;
`else
    // Two-flop latency, no debounce
    CAR = 1'b1;
    step();
    chk("sync_c_e0", 32'(C), 0);
    step();
    chk("sync_c_e1", 32'(C), 1);
    IC = 1'b1;
    step();
    chk("sync_ic_indep", 32'(C), 1);
    IC  = 1'b0;
    CAR = 1'b0;
    step();
    chk("sync_fall_e0", 32'(C), 1);
    step();
    chk("sync_fall_e1", 32'(C), 0);
    // Single-cycle pulse passes for exactly one cycle
    CAR = 1'b1;
    step();
    CAR = 1'b0;
    chk("pulse_c_e0", 32'(C), 0);
    step();
    chk("pulse_c_e1", 32'(C), 1);
    step();
    chk("pulse_c_e2", 32'(C), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, interval counter width in bits.
REQ-002 SHALL provide parameter SHORT, default 5, short-interval length in clk cycles.
REQ-003 SHALL provide parameter LONG, default 25, long-interval length in clk cycles.
REQ-004 SHALL provide parameter DEB, default 4, car-sensor debounce length in clk cycles.
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL provide port CLR  input  1  reset; synchronous, active-low.
REQ-007 SHALL provide port IC  input  1  interval clear from the traffic light controller.
REQ-008 SHALL provide port CAR  input  1  raw, asynchronous side-street car sensor.
REQ-009 SHALL provide port S  output  1  short interval elapsed.
REQ-010 SHALL provide port L  output  1  long interval elapsed.
REQ-011 SHALL provide port C  output  1  synchronized, optionally debounced car present.
REQ-012 SHALL provide port CNT  output  WIDTH  current interval count, for observation.

Function
REQ-013 SHALL hold a WIDTH-bit counter CNT; IC=1 at an edge loads CNT=0, otherwise CNT increments by 1.
REQ-014 SHALL saturate CNT at LONG, with no wrap-around; IC=1 at saturation still clears (IC has priority).
REQ-015 SHALL drive S = (CNT >= SHORT) and L = (CNT >= LONG), both decoded from the CNT register, with no extra latency.
REQ-016 Timing: IC sampled high at edge k, low afterwards -> S rises after edge k+SHORT, L rises after edge k+LONG.
REQ-017 SHALL keep CNT=0, S=0, L=0 while IC is held high.
REQ-018 SHALL pass CAR through a 2-flop synchronizer (SY1, SY2) before any other use.
REQ-019 Without debounce, SHALL drive C = SY2; CAR sampled at edge k appears on C after edge k+1.
REQ-020 With debounce, SHALL use a counter that increments each cycle SY2 != C and clears when SY2 == C.
REQ-021 With debounce, SHALL toggle C and clear the debounce counter when the counter reaches DEB-1 and SY2 != C.
REQ-022 With debounce, C changes only after SY2 has differed from C for DEB consecutive cycles; shorter glitches are suppressed.
REQ-023 SHALL make the timer and car paths independent; IC has no effect on C.
REQ-024 SHALL fail elaboration unless 1 <= SHORT < LONG <= 2^WIDTH-1 and DEB >= 1.

Reset
REQ-025 CLR=0 at a rising edge SHALL set CNT=0, SY1=SY2=0, C=0 and the debounce counter to 0, so S=0 and L=0.
REQ-026 CLR SHALL take priority over IC and CAR, including mid-interval and mid-debounce.
REQ-027 After CLR returns high, counting SHALL resume from 0 whether or not IC is high.

Configuration
REQ-028 Macro CAR_DEBOUNCE_EN defined: the debounce path of REQ-020 to REQ-022 is compiled in and DEB is used.
REQ-029 Macro CAR_DEBOUNCE_EN undefined: no debounce logic is built, C = SY2 (REQ-019), and DEB is ignored.

Verification
REQ-030 Reset, then a 1-cycle IC pulse at edge 0 with defaults -> S=1 from edge 5, L=1 from edge 25, CNT holds at 25 for 10 more cycles.
REQ-031 IC asserted at edge 12 during counting -> CNT=0 and S=0 after edge 12; S reasserts after edge 17.
REQ-032 IC held high for 30 cycles -> CNT, S and L stay 0 throughout; after release, S rises 5 edges after the last high IC.
REQ-033 CLR driven low at CNT=20 with IC low -> CNT=0, S=L=C=0 after that edge; counting restarts from 0.
REQ-034 CAR_DEBOUNCE_EN, DEB=4: a 3-cycle CAR pulse leaves C=0; CAR high from edge 0 -> C=1 after edge 5.
REQ-035 CAR_DEBOUNCE_EN undefined: CAR rises before edge 0 -> C=1 after edge 1; a 1-cycle pulse appears on C for 1 cycle.
